// File: rtl/boosted_reg_bank.sv
// ============================================================================
// Module  : boosted_reg_bank
// Purpose : 2R/1W register bank with write->read bypass and a one-register-
//           per-cycle clear sweep. Option macro: REG_BANK_ZERO_REG_EN
//           (reg[0] hardwired to zero).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module boosted_reg_bank #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam int                DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state_q,     state_d;
   logic [ADDR_W-1:0] clr_ptr_q,   clr_ptr_d;
   logic              clr_busy_q,  clr_busy_d;
   logic              clr_done_q,  clr_done_d;
   logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
   logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   logic wr_blocked;
   logic wr_ok;
   logic clr_ok;

`ifdef REG_BANK_ZERO_REG_EN
   assign wr_blocked = (wr_addr == '0);
`else
   assign wr_blocked = 1'b0;
`endif

   // Writes and the clear sweep never overlap: writes only land while idle.
   assign wr_ok  = wr_en && (state_q == ST_IDLE) && !wr_blocked;
   assign clr_ok = (state_q == ST_CLEAR);

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d   = ST_CLEAR;
               clr_ptr_d = '0;
            end
         end
         ST_CLEAR: begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_PTR) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Status flags are registered copies of the upcoming state.
      clr_busy_d = (state_d != ST_IDLE);
      clr_done_d = (state_d == ST_DONE);
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (wr_ok && (wr_addr == ADDR_W'(i))) begin
            mem_d[i] = wr_data;
         end
         if (clr_ok && (clr_ptr_q == ADDR_W'(i))) begin
            mem_d[i] = '0;
         end
      end
   end

   // Reads see this cycle's write or clear, not the stale contents.
   always_comb begin
      rd_data_a_d = mem_q[rd_addr_a];
      if (wr_ok && (wr_addr == rd_addr_a)) begin
         rd_data_a_d = wr_data;
      end
      if (clr_ok && (clr_ptr_q == rd_addr_a)) begin
         rd_data_a_d = '0;
      end

      rd_data_b_d = mem_q[rd_addr_b];
      if (wr_ok && (wr_addr == rd_addr_b)) begin
         rd_data_b_d = wr_data;
      end
      if (clr_ok && (clr_ptr_q == rd_addr_b)) begin
         rd_data_b_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         clr_ptr_q   <= '0;
         clr_busy_q  <= 1'b0;
         clr_done_q  <= 1'b0;
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         clr_busy_q  <= clr_busy_d;
         clr_done_q  <= clr_done_d;
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
         mem_q       <= mem_d;
      end
   end

   assign rd_data_a = rd_data_a_q;
   assign rd_data_b = rd_data_b_q;
   assign clr_busy  = clr_busy_q;
   assign clr_done  = clr_done_q;

endmodule

`default_nettype wire

// File: tb/tb_boosted_reg_bank.sv
// ============================================================================
// Module  : tb_boosted_reg_bank
// Purpose : Scoreboard bench for boosted_reg_bank with a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boosted_reg_bank;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;
`ifdef REG_BANK_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              clr_req;
   logic              clr_busy;
   logic              clr_done;

   boosted_reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .clr_req   (clr_req),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              busy;
      logic              done;
   } exp_t;

   exp_t exp_q[$];

   // Model: register contents plus a sweep position
   // (-1 idle, 0..DEPTH-1 clearing that index, DEPTH = done cycle).
   logic [DATA_W-1:0] model [DEPTH];
   int                sweep_pos = -1;
   int                n_checks  = 0;
   int                n_fails   = 0;

   function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a, input bit wacc);
      if (sweep_pos >= 0 && sweep_pos < DEPTH && sweep_pos == int'(a)) return '0;
      if (wacc && wr_addr == a) return wr_data;
      return model[a];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) model[i] = '0;
         sweep_pos = -1;
         exp_q.delete();
      end else begin
         exp_t e;
         bit   wacc;
         wacc = wr_en && (sweep_pos < 0) && !(ZERO_REG && wr_addr == '0);
         e.a  = model_read(rd_addr_a, wacc);
         e.b  = model_read(rd_addr_b, wacc);
         if (sweep_pos >= 0 && sweep_pos < DEPTH) model[sweep_pos] = '0;
         else if (wacc) model[wr_addr] = wr_data;
         if (sweep_pos < 0) begin
            if (clr_req) sweep_pos = 0;
         end else if (sweep_pos == DEPTH) begin
            sweep_pos = -1;
         end else begin
            sweep_pos = sweep_pos + 1;
         end
         e.busy = (sweep_pos >= 0);
         e.done = (sweep_pos == DEPTH);
         exp_q.push_back(e);
      end
   end

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s at %0t: got 0x%02h expected 0x%02h", name, $time, act, req);
      end
   endtask

   // Monitor: reset values while rst is high (including right after an
   // asynchronous assertion), otherwise one scoreboard entry per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or posedge rst);
         #1;
         if (rst) begin
            check("reset_rd_a", rd_data_a, 8'h00);
            check("reset_rd_b", rd_data_b, 8'h00);
            check("reset_busy", {7'd0, clr_busy}, 8'h00);
            check("reset_done", {7'd0, clr_done}, 8'h00);
         end else if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL no_expectation at %0t: got output with empty scoreboard, expected an entry", $time);
         end else begin
            e = exp_q.pop_front();
            check("rd_data_a", rd_data_a, e.a);
            check("rd_data_b", rd_data_b, e.b);
            check("clr_busy", {7'd0, clr_busy}, {7'd0, e.busy});
            check("clr_done", {7'd0, clr_done}, {7'd0, e.done});
         end
      end
   end

   task automatic cyc(input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb, input logic cr);
      @(negedge clk);
      #2;
      wr_addr   = wa;
      wr_data   = wd;
      rd_addr_a = ra;
      rd_addr_b = rb;
      clr_req   = cr;
   endtask

   task automatic rnd_cyc(input logic cr);
      cyc(ADDR_W'($urandom_range(0, DEPTH-1)), DATA_W'($urandom_range(0, 255)),
          ADDR_W'($urandom_range(0, DEPTH-1)), ADDR_W'($urandom_range(0, DEPTH-1)), cr);
   endtask

   task automatic read_all();
      for (int i = 0; i < DEPTH; i++)
         cyc(ADDR_W'((i + 4) % DEPTH), 8'h00, ADDR_W'(i), ADDR_W'(DEPTH - 1 - i), 1'b0);
   endtask

   initial begin
      int hold;
      hold      = 0;
      rst       = 1'b0;
      wr_en     = 1'b1;
      wr_addr   = '0;
      wr_data   = '0;
      rd_addr_a = '0;
      rd_addr_b = '0;
      clr_req   = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;

      read_all();

      cyc(3'd3, 8'hA5, 3'd0, 3'd1, 1'b0);
      cyc(3'd0, 8'h00, 3'd3, 3'd3, 1'b0);
      cyc(3'd5, 8'h3C, 3'd5, 3'd5, 1'b0);
      cyc(3'd0, 8'h00, 3'd5, 3'd3, 1'b0);

      for (int i = 0; i < DEPTH; i++)
         cyc(ADDR_W'(i), DATA_W'($urandom_range(1, 255)), ADDR_W'(i), 3'd3, 1'b0);
      cyc(3'd2, 8'h77, 3'd2, 3'd6, 1'b1);
      for (int i = 0; i < DEPTH + 1; i++) rnd_cyc(1'b0);
      read_all();

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) == 0) hold = 12;
         rnd_cyc(($urandom_range(0, 19) == 0) || (hold > 0));
         if (hold > 0) hold--;
      end
      cyc(3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
      repeat (DEPTH + 2) rnd_cyc(1'b0);

      for (int i = 0; i < DEPTH; i++)
         cyc(ADDR_W'(i), DATA_W'($urandom_range(1, 255)), ADDR_W'(i), 3'd0, 1'b0);
      cyc(3'd1, 8'h11, 3'd4, 3'd5, 1'b1);
      repeat (4) rnd_cyc(1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      read_all();

      cyc(3'd0, 8'hFF, 3'd1, 3'd2, 1'b0);
      cyc(3'd1, 8'h00, 3'd0, 3'd0, 1'b0);
      cyc(3'd0, 8'hFF, 3'd0, 3'd0, 1'b0);
      cyc(3'd2, 8'h00, 3'd0, 3'd2, 1'b0);

      repeat (3) @(negedge clk);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
